// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding for the DMA data buffer
package dma_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    STORE = 2'b10
  } dma_buf_state_t;
endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: DEPTH-entry synchronous FIFO with extra-bit pointers and flush
module dma_sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic do_push, do_pop;
  assign count_o = wr_q - rd_q;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign empty_o = wr_q == rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // Pointer advance; flush wins over any push or pop in the same cycle
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = flush_i ? '0 : rd_q + (AW+1)'(do_pop);
  end
  // Pointer registers, cleared by reset so buffered words are discarded
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // Storage array is never cleared; only the pointers define valid data
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/dma_data_buffer.sv
// dma_data_buffer: CPU register data path plus mem-to-mem burst FIFO on the external bus
module dma_data_buffer
  import dma_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          RESET,
  inout  wire  [DW-1:0] Data_bus_ex,
  input  logic [DW-1:0] in_dataBuffer,
  output logic [DW-1:0] out_dataBuffer,
  output logic          cpu_wr_stb,
  input  logic          CS,
  input  logic          IOR,
  input  logic          IOW,
  input  logic          HLDA,
  input  logic          MemToMem,
  input  logic          MEMRW,
  input  logic          Data_flag,
  input  logic          IReady,
  input  logic          flush,
  output logic          flag_data_ready,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic [1:0]    state
);
  dma_buf_state_t state_q, state_d;
  logic [DW-1:0] out_q, head;
  logic ready_q, wr_act_q, stb_q, ovf_q, udf_q;
  logic rdy_rise, cpu_wr, push, pop, slave_drv, master_drv;
  assign rdy_rise   = IReady & ~ready_q;
  assign cpu_wr     = (state_q == IDLE) & ~CS & ~IOW;
  assign push       = (state_q == FETCH) & rdy_rise;
  assign pop        = (state_q == STORE) & rdy_rise & Data_flag;
  assign slave_drv  = RESET & ~HLDA & ~CS & ~IOR;
  assign master_drv = HLDA & (state_q == STORE) & Data_flag & ~empty;
  assign Data_bus_ex = slave_drv ? in_dataBuffer : master_drv ? head : {DW{1'bz}};
  assign out_dataBuffer  = out_q;
  assign cpu_wr_stb      = stb_q;
  assign flag_data_ready = ~empty;
  assign ovf   = ovf_q;
  assign udf   = udf_q;
  assign state = state_q;
  // Next state follows the bus-grant and transfer-direction inputs only
  always_comb begin
    state_d = (~HLDA | ~MemToMem) ? IDLE : (MEMRW ? STORE : FETCH);
  end
  // FSM, ready edge history, CPU write capture and sticky error flags
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      wr_act_q <= 1'b0;
      stb_q    <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= IReady;
      wr_act_q <= cpu_wr;
      stb_q    <= cpu_wr & ~wr_act_q;
      if (cpu_wr) out_q <= Data_bus_ex;
      ovf_q    <= ~flush & (ovf_q | (push & full));
      udf_q    <= ~flush & (udf_q | (pop & empty));
    end
  end
  dma_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .RESET   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (Data_bus_ex),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_dma_data_buffer.sv
// tb_dma_data_buffer: directed checks of slave access, burst FIFO, errors, wrap and async reset
module tb_dma_data_buffer;
  logic clk = 1'b0;
  logic RESET;
  wire  [7:0] bus;
  logic [7:0] tb_bus, in_db;
  logic tb_drv;
  logic CS, IOR, IOW, HLDA, MemToMem, MEMRW, Data_flag, IReady, flush;
  logic [7:0] out_db;
  logic cpu_wr_stb, fdr, full, empty, ovf, udf;
  logic [2:0] count;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  logic [7:0] wdat [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hB4, 8'hB5, 8'hB6};
  logic [7:0] bdat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always #5 clk = ~clk;

  assign bus = tb_drv ? tb_bus : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  dma_data_buffer #(.DW(8), .DEPTH(4)) dut (
    .clk             (clk),
    .RESET           (RESET),
    .Data_bus_ex     (bus),
    .in_dataBuffer   (in_db),
    .out_dataBuffer  (out_db),
    .cpu_wr_stb      (cpu_wr_stb),
    .CS              (CS),
    .IOR             (IOR),
    .IOW             (IOW),
    .HLDA            (HLDA),
    .MemToMem        (MemToMem),
    .MEMRW           (MEMRW),
    .Data_flag       (Data_flag),
    .IReady          (IReady),
    .flush           (flush),
    .flag_data_ready (fdr),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .ovf             (ovf),
    .udf             (udf),
    .state           (state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input int hold);
    tb_drv = 1'b1;
    tb_bus = v;
    IReady = 1'b1;
    repeat (hold) tick();
    IReady = 1'b0;
    tick();
  endtask

  task automatic pop();
    IReady = 1'b1;
    tick();
    IReady = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b0; tb_drv = 1'b0; tb_bus = '0; in_db = '0;
    CS = 1'b1; IOR = 1'b1; IOW = 1'b1; HLDA = 1'b0; MemToMem = 1'b0;
    MEMRW = 1'b0; Data_flag = 1'b0; IReady = 1'b0; flush = 1'b0;
    #12;
    check("rst_state", {6'b0, state}, 8'h00);
    check("rst_out", out_db, 8'h00);
    check("rst_stb", {7'b0, cpu_wr_stb}, 8'h00);
    check("rst_count", {5'b0, count}, 8'h00);
    check("rst_empty", {7'b0, empty}, 8'h01);
    check("rst_full", {7'b0, full}, 8'h00);
    check("rst_fdr", {7'b0, fdr}, 8'h00);
    check("rst_errs", {6'b0, ovf, udf}, 8'h00);
    check("rst_bus", bus, 8'hFF);
    @(negedge clk);
    RESET = 1'b1;
    tick();
    CS = 1'b0; IOW = 1'b0; tb_drv = 1'b1; tb_bus = 8'hA5;
    tick();
    check("wr_out", out_db, 8'hA5);
    check("wr_stb1", {7'b0, cpu_wr_stb}, 8'h01);
    tick();
    check("wr_stb2", {7'b0, cpu_wr_stb}, 8'h00);
    tick();
    check("wr_stb3", {7'b0, cpu_wr_stb}, 8'h00);
    check("wr_hold", out_db, 8'hA5);
    CS = 1'b1; IOW = 1'b1; tb_drv = 1'b0;
    tick();
    CS = 1'b0; IOR = 1'b0; in_db = 8'h3C;
    #1;
    check("rd_bus", bus, 8'h3C);
    CS = 1'b1; IOR = 1'b1;
    #1;
    check("rd_release", bus, 8'hFF);
    HLDA = 1'b1; MemToMem = 1'b1; MEMRW = 1'b0;
    tick();
    check("fetch_state", {6'b0, state}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      push(bdat[i], (i == 1) ? 3 : 1);
      check($sformatf("burst_cnt%0d", i), {5'b0, count}, 8'(i + 1));
    end
    check("burst_full", {7'b0, full}, 8'h01);
    check("burst_fdr", {7'b0, fdr}, 8'h01);
    check("burst_ovf0", {7'b0, ovf}, 8'h00);
    push(bdat[4], 1);
    check("ovf_flag", {7'b0, ovf}, 8'h01);
    check("ovf_count", {5'b0, count}, 8'h04);
    tb_drv = 1'b0; MEMRW = 1'b1; Data_flag = 1'b1;
    tick();
    check("store_state", {6'b0, state}, 8'h02);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_bus%0d", i), bus, bdat[i]);
      pop();
      check($sformatf("drain_cnt%0d", i), {5'b0, count}, 8'(3 - i));
    end
    check("drain_empty", {7'b0, empty}, 8'h01);
    check("drain_bus_z", bus, 8'hFF);
    pop();
    check("udf_flag", {7'b0, udf}, 8'h01);
    check("udf_count", {5'b0, count}, 8'h00);
    check("udf_bus_z", bus, 8'hFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_udf", {7'b0, udf}, 8'h00);
    check("flush_ovf", {7'b0, ovf}, 8'h00);
    for (int r = 0; r < 2; r++) begin
      MEMRW = 1'b0; Data_flag = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
        push(wdat[3*r+i], 1);
        check($sformatf("wrap_push_cnt%0d_%0d", r, i), {5'b0, count}, 8'(i + 1));
      end
      tb_drv = 1'b0; MEMRW = 1'b1; Data_flag = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("wrap_bus%0d_%0d", r, i), bus, wdat[3*r+i]);
        pop();
        check($sformatf("wrap_pop_cnt%0d_%0d", r, i), {5'b0, count}, 8'(2 - i));
      end
    end
    check("wrap_udf", {7'b0, udf}, 8'h00);
    MEMRW = 1'b0; Data_flag = 1'b0;
    tick();
    push(8'hC1, 1);
    push(8'hC2, 1);
    tb_drv = 1'b0; MEMRW = 1'b1; Data_flag = 1'b1;
    tick();
    check("mid_bus", bus, 8'hC1);
    check("mid_count", {5'b0, count}, 8'h02);
    #2;
    RESET = 1'b0;
    #1;
    check("arst_count", {5'b0, count}, 8'h00);
    check("arst_empty", {7'b0, empty}, 8'h01);
    check("arst_fdr", {7'b0, fdr}, 8'h00);
    check("arst_state", {6'b0, state}, 8'h00);
    check("arst_bus", bus, 8'hFF);
    check("arst_out", out_db, 8'h00);
    #5;
    RESET = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
